// File: rtl/icg_pkg.sv
// -----------------------------------------------------------------------------
// icg_pkg
// Shared types and constants for the integrated clock-gating cell (icg_cell).
//
// Contents:
//   gate_style_e   gating style: GATE_OR (idle high) / GATE_AND (idle low)
//   ICG_IDLE_AND   parked level of the gated clock for AND-type gating
//   ICG_IDLE_OR    parked level of the gated clock for OR-type gating
//   idle_level()   parked level for a given style
//   latch_open()   enable-latch transparency for a given clock level and style
//
// Optional feature macro used by files that import this package:
//   ICG_SCAN_TEST_EN
// -----------------------------------------------------------------------------
package icg_pkg;

    typedef enum logic {
        GATE_OR  = 1'b0,
        GATE_AND = 1'b1
    } gate_style_e;

    localparam logic ICG_IDLE_AND = 1'b0;
    localparam logic ICG_IDLE_OR  = 1'b1;

    function automatic logic idle_level(input gate_style_e style);
        return (style == GATE_AND) ? ICG_IDLE_AND : ICG_IDLE_OR;
    endfunction

    // The latch must be transparent only during the phase in which the gated
    // clock is parked, so that a new enable can never cut an active phase.
    // AND-type is active high, so it opens while clk is low; OR-type is
    // active low, so it opens while clk is high.
    function automatic logic latch_open(input logic clk, input gate_style_e style);
        return (style == GATE_AND) ? ~clk : clk;
    endfunction

endpackage

// File: rtl/icg_cell_if.sv
// -----------------------------------------------------------------------------
// icg_cell_if
// Bundles the functional control/observation signals of icg_cell. The source
// clock and reset stay as plain ports of the cell.
//
// Signals:
//   en            functional clock enable (asynchronous to clk_in phase)
//   active_value  gating style: 1 = AND-type (idle low), 0 = OR-type (idle high)
//   test_en       scan-test enable, present only with ICG_SCAN_TEST_EN defined
//   clk_gated     gated clock
//   en_latched    current enable-latch content
//
// Modports:
//   master  drives the controls, observes the gated clock (controller / bench)
//   slave   the gating cell itself
//
// Configuration macro: ICG_SCAN_TEST_EN (adds test_en)
// -----------------------------------------------------------------------------
interface icg_cell_if;

    logic en;
    logic active_value;
`ifdef ICG_SCAN_TEST_EN
    logic test_en;
`endif
    logic clk_gated;
    logic en_latched;

    modport master (
`ifdef ICG_SCAN_TEST_EN
        output test_en,
`endif
        output en,
        output active_value,
        input  clk_gated,
        input  en_latched
    );

    modport slave (
`ifdef ICG_SCAN_TEST_EN
        input  test_en,
`endif
        input  en,
        input  active_value,
        output clk_gated,
        output en_latched
    );

endinterface

// File: rtl/icg_en_latch.sv
// -----------------------------------------------------------------------------
// icg_en_latch
// Level-sensitive enable latch with a style-selected transparent phase and a
// synchronous reset override.
//
// Parameters:
//   RST_VAL   value loaded while rst_ovr is high
//
// Ports:
//   clk       in   source clock (used as the latch gate)
//   style     in   gating style; selects the transparent phase
//   rst_ovr   in   registered reset; forces RST_VAL at the next open phase
//   d         in   requested enable
//   q         out  latched enable
// -----------------------------------------------------------------------------
module icg_en_latch
    import icg_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic        clk,
    input  gate_style_e style,
    input  logic        rst_ovr,
    input  logic        d,
    output logic        q
);

    logic lat_open;
    logic d_eff;

    assign lat_open = latch_open(clk, style);

    // Reset only acts through the latch, so it is subject to the same
    // phase restriction as the enable and can never clip an active phase.
    assign d_eff = rst_ovr ? RST_VAL : d;

    always_latch begin
        if (lat_open) begin
            q <= d_eff;
        end
    end

endmodule

// File: rtl/icg_cell.sv
// -----------------------------------------------------------------------------
// icg_cell
// Integrated clock-gating cell. Passes or blocks clk_in onto clk_gated under a
// functional enable, using a level-sensitive enable latch so the gated clock
// never produces a pulse shorter than the clk_in phase it follows.
// Two run-time styles: AND-type (gated clock parks low) and OR-type (parks high).
//
// Parameters:
//   RST_EN_VAL    value loaded into the enable latch while reset is active
//
// Ports:
//   clk_in        in   free-running source clock
//   rst           in   synchronous active-high reset, sampled on posedge clk_in
//   bus           icg_cell_if.slave: en, active_value, [test_en],
//                 clk_gated, en_latched
//
// Configuration macro:
//   ICG_SCAN_TEST_EN  when defined, the latch input is (en | test_en) so scan
//                     shift clocks the branch regardless of en
// -----------------------------------------------------------------------------
module icg_cell
    import icg_pkg::*;
#(
    parameter logic RST_EN_VAL = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst,
    icg_cell_if.slave  bus
);

    logic        rst_q;
    logic        en_req;
    logic        en_q;
    logic        gated;
    gate_style_e style;

    always_ff @(posedge clk_in) begin
        rst_q <= rst;
    end

    assign style = gate_style_e'(bus.active_value);

    // Priority rst_q > test_en > en: rst_q is applied inside the latch as an
    // override of whatever request is presented here.
`ifdef ICG_SCAN_TEST_EN
    assign en_req = bus.en | bus.test_en;
`else
    assign en_req = bus.en;
`endif

    icg_en_latch #(
        .RST_VAL (RST_EN_VAL)
    ) u_en_latch (
        .clk     (clk_in),
        .style   (style),
        .rst_ovr (rst_q),
        .d       (en_req),
        .q       (en_q)
    );

    // en_q only changes while clk_in sits at the idle level of the selected
    // style, so either gate form switches cleanly.
    always_comb begin
        gated = idle_level(style);
        if (style == GATE_AND) begin
            gated = clk_in & en_q;
        end else begin
            gated = clk_in | ~en_q;
        end
    end

    assign bus.clk_gated  = gated;
    assign bus.en_latched = en_q;

endmodule

// File: tb/tb_icg_cell.sv
`timescale 1ns/1ps
module tb_icg_cell;

    typedef struct {
        longint start;
        longint width;
    } pulse_t;

    logic clk_in = 1'b0;
    logic rst;

    icg_cell_if bus ();

    icg_cell #(
        .RST_EN_VAL (1'b0)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int     total = 0;
    int     bad   = 0;
    pulse_t exp_q[$];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0d: got %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_num(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0d: got %0d, required %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_pulse(input longint s);
        exp_q.push_back('{start: s, width: 5});
    endtask

    task automatic at(input longint t);
        #(t - longint'($time));
    endtask

    task automatic score(input longint s, input longint w);
        pulse_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got start=%0d width=%0d, required no pulse", s, w);
        end else begin
            e = exp_q.pop_front();
            chk_num("pulse_start", s, e.start);
            chk_num("pulse_width", w, e.width);
        end
    endtask

    // Monitor: an active phase is high for AND-type, low for OR-type.
    logic   mon_style;
    bit     in_pulse;
    longint t_start;

    initial begin
        mon_style = 1'b1;
        in_pulse  = 1'b0;
        t_start   = 0;
        forever begin
            @(bus.clk_gated or bus.active_value);
            if (bus.active_value !== mon_style) begin
                mon_style = bus.active_value;
                in_pulse  = 1'b0;
            end else if (bus.clk_gated === mon_style) begin
                in_pulse = 1'b1;
                t_start  = longint'($time);
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                score(t_start, longint'($time) - t_start);
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.en           = 1'b0;
        bus.active_value = 1'b1;
`ifdef ICG_SCAN_TEST_EN
        bus.test_en      = 1'b0;
`endif
        at(17);
        chk_bit("rst_en_latched", bus.en_latched, 1'b0);
        chk_bit("rst_gated_low", bus.clk_gated, 1'b0);
        at(20);
        rst = 1'b0;

        // 1: AND-type, enable while clk low -> 6 pulses
        at(52);  bus.en = 1'b1;
        for (int i = 0; i < 6; i++) push_pulse(55 + 10 * i);
        at(53);  chk_bit("t1_en_latched", bus.en_latched, 1'b1);
        at(112); bus.en = 1'b0;
        at(118);
        chk_bit("t1_idle", bus.clk_gated, 1'b0);
        chk_bit("t1_en_latched_off", bus.en_latched, 1'b0);
        chk_num("t1_pending", exp_q.size(), 0);

        // 2: enable rises / falls mid-high-phase
        at(157); bus.en = 1'b1;
        for (int i = 0; i < 4; i++) push_pulse(165 + 10 * i);
        at(158);
        chk_bit("t2_opaque", bus.en_latched, 1'b0);
        chk_bit("t2_no_partial", bus.clk_gated, 1'b0);
        at(197); bus.en = 1'b0;
        at(203); chk_num("t2_pending", exp_q.size(), 0);

        // 3: non-aligned enable pulses of 15/24/38 ns, then a glitch in opaque phase
        at(213); bus.en = 1'b1; push_pulse(215); push_pulse(225);
        at(228); bus.en = 1'b0;
        at(242); bus.en = 1'b1;
        for (int i = 0; i < 3; i++) push_pulse(245 + 10 * i);
        at(266); bus.en = 1'b0;
        at(288); bus.en = 1'b1;
        for (int i = 0; i < 4; i++) push_pulse(295 + 10 * i);
        at(326); bus.en = 1'b0;
        at(336); bus.en = 1'b1;
        at(338); chk_bit("t3_glitch_blocked", bus.clk_gated, 1'b0);
        at(339); bus.en = 1'b0;
        at(342);
        chk_bit("t3_en_latched_off", bus.en_latched, 1'b0);
        chk_num("t3_pending", exp_q.size(), 0);

        // 4: OR-type, same enable pattern as test 1
        at(352); bus.active_value = 1'b0;
        at(362); chk_bit("t4_or_idle", bus.clk_gated, 1'b1);
        at(382); bus.en = 1'b1;
        for (int i = 0; i < 6; i++) push_pulse(390 + 10 * i);
        at(383); chk_bit("t4_opaque", bus.en_latched, 1'b0);
        at(386); chk_bit("t4_en_latched", bus.en_latched, 1'b1);
        at(442); bus.en = 1'b0;
        at(448); chk_num("t4_pending", exp_q.size(), 0);
        at(451); chk_bit("t4_or_idle_after", bus.clk_gated, 1'b1);

        // 5a: reset during OR-type gating
        at(452); bus.en = 1'b1; push_pulse(460); push_pulse(470);
        at(473); rst = 1'b1;
        at(478); chk_bit("t5_or_rst_latched", bus.en_latched, 1'b0);
        at(482); chk_bit("t5_or_rst_idle", bus.clk_gated, 1'b1);
        at(492); rst = 1'b0;
        for (int i = 0; i < 3; i++) push_pulse(500 + 10 * i);
        at(497); chk_bit("t5_or_resume", bus.en_latched, 1'b1);
        at(522); bus.en = 1'b0;
        at(528); chk_num("t5_or_pending", exp_q.size(), 0);

        // 5b: back to AND-type while disabled, then reset during gating
        at(532); bus.active_value = 1'b1;
        at(533); chk_bit("t5_and_idle_switch", bus.clk_gated, 1'b0);
        at(542); bus.en = 1'b1;
        for (int i = 0; i < 3; i++) push_pulse(545 + 10 * i);
        at(557); rst = 1'b1;
        at(572); chk_bit("t5_and_rst_latched", bus.en_latched, 1'b0);
        at(577);
        chk_bit("t5_and_rst_idle", bus.clk_gated, 1'b0);
        rst = 1'b0;
        push_pulse(595); push_pulse(605);
        at(587); chk_bit("t5_and_still_reset", bus.en_latched, 1'b0);
        at(612); bus.en = 1'b0;
        at(618); chk_num("t5_and_pending", exp_q.size(), 0);

`ifdef ICG_SCAN_TEST_EN
        // 6: scan enable clocks the branch with en low
        at(622); bus.test_en = 1'b1;
        for (int i = 0; i < 4; i++) push_pulse(625 + 10 * i);
        at(656); bus.test_en = 1'b0;
        at(663);
        chk_bit("t6_en_latched_off", bus.en_latched, 1'b0);
        chk_num("t6_pending", exp_q.size(), 0);
`endif

        at(690);
        chk_bit("final_idle", bus.clk_gated, 1'b0);
        chk_num("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
